// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB writeback and ID read-port bundle.
//   master: drives the wb_* writeback controls and the rs/rt read addresses.
//   slave : the register file; returns the read data, the writeback value and the debug state.
interface wb_regfile_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] wb_readvalue;
    logic [DATA_W-1:0] wb_aluvalue;
    logic [4:0]        wb_rd;
    logic              wb_memtoreg;
    logic              wb_regwrite;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       wr_count;
    logic [4:0]        last_rd;
    logic [DATA_W-1:0] last_data;

    modport master (
        output wb_readvalue, wb_aluvalue, wb_rd, wb_memtoreg, wb_regwrite, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wr_count, last_rd, last_data
    );
    modport slave (
        input  wb_readvalue, wb_aluvalue, wb_rd, wb_memtoreg, wb_regwrite, rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wr_count, last_rd, last_data
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux plus a 32 x DATA_W register file with write-through read ports.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears the array, the counter and the last-write capture
//   bus   : wb_regfile_if slave; wb_* writeback inputs, rs/rt read ports, wb_data, wr_count, last_rd, last_data
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input logic         clk,
    input logic         rst_n,
    wb_regfile_if.slave bus
);
    logic [DATA_W-1:0] r_regs [NREG];
    logic [31:0]       r_wr_count;
    logic [4:0]        r_last_rd;
    logic [DATA_W-1:0] r_last_data;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_commit;

    assign w_wb_data = bus.wb_memtoreg ? bus.wb_readvalue : bus.wb_aluvalue;
    assign w_commit  = bus.wb_regwrite && bus.wb_rd != 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_wr_count  <= '0;
            r_last_rd   <= '0;
            r_last_data <= '0;
        end else if (w_commit) begin
            r_regs[bus.wb_rd] <= w_wb_data;
            r_wr_count        <= r_wr_count + 32'd1;
            r_last_rd         <= bus.wb_rd;
            r_last_data       <= w_wb_data;
        end
    end

    // rst_n gating keeps the bypass path from leaking wb_data while the array is held clear
    always_comb begin
        bus.rs_data = (!rst_n || bus.rs_addr == 5'd0) ? '0 :
                      (w_commit && bus.rs_addr == bus.wb_rd) ? w_wb_data : r_regs[bus.rs_addr];
        bus.rt_data = (!rst_n || bus.rt_addr == 5'd0) ? '0 :
                      (w_commit && bus.rt_addr == bus.wb_rd) ? w_wb_data : r_regs[bus.rt_addr];
    end

    assign bus.wb_data   = w_wb_data;
    assign bus.wr_count  = r_wr_count;
    assign bus.last_rd   = r_last_rd;
    assign bus.last_data = r_last_data;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    wb_regfile_if #(.DATA_W(32)) bus ();

    wb_regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] rd, input logic m2r,
                         input logic [31:0] rv, input logic [31:0] av);
        bus.wb_regwrite  = we;
        bus.wb_rd        = rd;
        bus.wb_memtoreg  = m2r;
        bus.wb_readvalue = rv;
        bus.wb_aluvalue  = av;
    endtask

    task automatic commit(input logic [4:0] rd, input logic m2r,
                          input logic [31:0] rv, input logic [31:0] av);
        @(negedge clk);
        drive(1'b1, rd, m2r, rv, av);
        @(posedge clk);
        #1;
        bus.wb_regwrite = 1'b0;
    endtask

    task automatic test_reset;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        bus.rs_addr = 5'd1;
        bus.rt_addr = 5'd2;
        #2;
        n_tests++;
        if (bus.wr_count !== 32'd0) begin n_fail++; $display("FAIL reset_wr_count got %h want %h", bus.wr_count, 32'd0); end
        n_tests++;
        if (bus.last_rd !== 5'd0 || bus.last_data !== 32'd0) begin n_fail++; $display("FAIL reset_last got %0d/%h want 0/0", bus.last_rd, bus.last_data); end
        n_tests++;
        if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin n_fail++; $display("FAIL reset_reads got %h/%h want 0/0", bus.rs_data, bus.rt_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mux_commit;
        @(negedge clk);
        drive(1'b1, 5'd3, 1'b1, 32'hDEADBEEF, 32'h11);
        #1;
        n_tests++;
        if (bus.wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mux_load got %h want %h", bus.wb_data, 32'hDEADBEEF); end
        @(posedge clk);
        #1;
        bus.wb_regwrite = 1'b0;
        bus.rs_addr = 5'd3;
        #1;
        n_tests++;
        if (bus.rs_data !== 32'hDEADBEEF || bus.wr_count !== 32'd1) begin n_fail++; $display("FAIL commit_load got %h cnt %0d want deadbeef cnt 1", bus.rs_data, bus.wr_count); end
        n_tests++;
        if (bus.last_rd !== 5'd3 || bus.last_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL last_load got %0d/%h want 3/deadbeef", bus.last_rd, bus.last_data); end
        commit(5'd3, 1'b0, 32'hDEADBEEF, 32'h11);
        #1;
        n_tests++;
        if (bus.rs_data !== 32'h11 || bus.wr_count !== 32'd2 || bus.last_data !== 32'h11) begin
            n_fail++; $display("FAIL commit_alu got %h cnt %0d last %h want 11 cnt 2 last 11", bus.rs_data, bus.wr_count, bus.last_data);
        end
    endtask

    task automatic test_bypass;
        commit(5'd7, 1'b0, 32'h0, 32'h1);
        @(negedge clk);
        bus.rs_addr = 5'd7;
        bus.rt_addr = 5'd7;
        drive(1'b1, 5'd7, 1'b0, 32'h0, 32'hA5A5A5A5);
        #1;
        n_tests++;
        if (bus.rs_data !== 32'hA5A5A5A5 || bus.rt_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_both got %h/%h want a5a5a5a5", bus.rs_data, bus.rt_data); end
        bus.wb_regwrite = 1'b0;
        #1;
        n_tests++;
        if (bus.rs_data !== 32'h1 || bus.rt_data !== 32'h1) begin n_fail++; $display("FAIL bypass_off got %h/%h want 1/1", bus.rs_data, bus.rt_data); end
        bus.wb_regwrite = 1'b1;
        @(posedge clk);
        #1;
        bus.wb_regwrite = 1'b0;
        #1;
        n_tests++;
        if (bus.rs_data !== 32'hA5A5A5A5 || bus.rt_data !== 32'hA5A5A5A5 || bus.wr_count !== 32'd4) begin
            n_fail++; $display("FAIL bypass_commit got %h/%h cnt %0d want a5a5a5a5 cnt 4", bus.rs_data, bus.rt_data, bus.wr_count);
        end
    endtask

    task automatic test_x0_write;
        @(negedge clk);
        bus.rs_addr = 5'd0;
        drive(1'b1, 5'd0, 1'b0, 32'h0, 32'hFFFFFFFF);
        #1;
        n_tests++;
        if (bus.rs_data !== 32'd0) begin n_fail++; $display("FAIL x0_before got %h want 0", bus.rs_data); end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rs_data !== 32'd0 || bus.wr_count !== 32'd4 || bus.last_rd !== 5'd7 || bus.last_data !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL x0_after got %h cnt %0d last %0d/%h want 0 cnt 4 last 7/a5a5a5a5", bus.rs_data, bus.wr_count, bus.last_rd, bus.last_data);
        end
        @(negedge clk);
        drive(1'b0, 5'd9, 1'b0, 32'h0, 32'h99);
        bus.rs_addr = 5'd9;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rs_data !== 32'd0 || bus.wr_count !== 32'd4) begin n_fail++; $display("FAIL no_regwrite got %h cnt %0d want 0 cnt 4", bus.rs_data, bus.wr_count); end
    endtask

    task automatic test_sweep;
        logic [31:0] ea;
        logic [31:0] eb;
        int bad;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) commit(5'(i), 1'b0, 32'h0, (32'(i) << 8) | 32'(i));
        #1;
        n_tests++;
        if (bus.wr_count !== 32'd31 || bus.last_rd !== 5'd31 || bus.last_data !== 32'h1F1F) begin
            n_fail++; $display("FAIL sweep_state cnt %0d last %0d/%h want 31 last 31/1f1f", bus.wr_count, bus.last_rd, bus.last_data);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            bus.rs_addr = 5'(i);
            bus.rt_addr = 5'(31 - i);
            ea = (i == 0) ? 32'd0 : ((32'(i) << 8) | 32'(i));
            eb = (i == 31) ? 32'd0 : ((32'(31 - i) << 8) | 32'(31 - i));
            #1;
            if (bus.rs_data !== ea || bus.rt_data !== eb) begin
                bad++; $display("FAIL sweep_read idx %0d got %h/%h want %h/%h", i, bus.rs_data, bus.rt_data, ea, eb);
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.r_wr_count = 32'hFFFFFFFF;
        #1;
        release dut.r_wr_count;
        #1;
        n_tests++;
        if (bus.wr_count !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffffffff", bus.wr_count); end
        commit(5'd2, 1'b1, 32'h2222, 32'h0);
        bus.rs_addr = 5'd2;
        #1;
        n_tests++;
        if (bus.wr_count !== 32'd0 || bus.rs_data !== 32'h2222) begin n_fail++; $display("FAIL wrap got cnt %h x2 %h want 0 x2 2222", bus.wr_count, bus.rs_data); end
    endtask

    task automatic test_reset_midrun;
        commit(5'd5, 1'b0, 32'h0, 32'h1234);
        bus.rs_addr = 5'd5;
        #1;
        n_tests++;
        if (bus.rs_data !== 32'h1234) begin n_fail++; $display("FAIL pre_reset got %h want 1234", bus.rs_data); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.rs_data !== 32'd0 || bus.wr_count !== 32'd0 || bus.last_rd !== 5'd0 || bus.last_data !== 32'd0) begin
            n_fail++; $display("FAIL midrun_reset got %h cnt %0d last %0d/%h want all 0", bus.rs_data, bus.wr_count, bus.last_rd, bus.last_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        commit(5'd6, 1'b0, 32'h0, 32'h66);
        bus.rs_addr = 5'd6;
        #1;
        n_tests++;
        if (bus.rs_data !== 32'h66 || bus.wr_count !== 32'd1 || bus.last_rd !== 5'd6) begin
            n_fail++; $display("FAIL post_reset got %h cnt %0d last %0d want 66 cnt 1 last 6", bus.rs_data, bus.wr_count, bus.last_rd);
        end
    endtask

    initial begin
        test_reset;
        test_mux_commit;
        test_bypass;
        test_x0_write;
        test_sweep;
        test_wrap;
        test_reset_midrun;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
